// File: rtl/change_dispenser.sv
// Refund payout engine: latches credit on a refund edge and pays it out coin by coin
// through a pound/20p hopper using a strobe/ack handshake, reporting done or fault.
module change_dispenser #(
  parameter int W           = 12,
  parameter int PULSE_CYC   = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int GAP_CYC     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refund_req,
  input  logic [W-1:0] credit,
  input  logic         pound_empty,
  input  logic         p20_empty,
  input  logic         hopper_ack,
  input  logic         fault_clr,
  output logic         credit_clr,
  output logic         eject_pound,
  output logic         eject_20p,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [W-1:0] balance,
  output logic [7:0]   pounds_out,
  output logic [7:0]   p20_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT_P, S_EJECT_20, S_WAIT_ACK, S_GAP, S_DONE, S_FAULT
  } state_t;

  // One shared timer serves the strobe width, the ack wait and the inter-coin gap.
  localparam int             TW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]  PULSE_LAST = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0]  GAP_LAST   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0]  ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [W-1:0]   POUND      = W'(100);
  localparam logic [W-1:0]   P20        = W'(20);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  balance_q, balance_d;
  logic [7:0]    pounds_q, pounds_d;
  logic [7:0]    p20_q, p20_d;
  logic          is_pound_q, is_pound_d;
  logic          req_prev_q, req_prev_d;
  logic          credit_clr_q, credit_clr_d;
  logic          eject_pound_q, eject_pound_d;
  logic          eject_20p_q, eject_20p_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    timer_d      = timer_q;
    balance_d    = balance_q;
    pounds_d     = pounds_q;
    p20_d        = p20_q;
    is_pound_d   = is_pound_q;
    req_prev_d   = refund_req;
    credit_clr_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (refund_req && !req_prev_q) begin
          balance_d    = credit;
          pounds_d     = '0;
          p20_d        = '0;
          credit_clr_d = 1'b1;
          state_d      = S_SELECT;
        end
      end
      S_SELECT: begin
        timer_d = '0;
        if (balance_q == '0) begin
          state_d = S_DONE;
        end else if (balance_q >= POUND && !pound_empty) begin
          is_pound_d = 1'b1;
          state_d    = S_EJECT_P;
        end else if (balance_q >= P20 && !p20_empty) begin
          is_pound_d = 1'b0;
          state_d    = S_EJECT_20;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_EJECT_P, S_EJECT_20: begin
        if (timer_q == PULSE_LAST) begin
          timer_d = '0;
          state_d = S_WAIT_ACK;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (hopper_ack) begin
          timer_d = '0;
          state_d = S_GAP;
          if (is_pound_q) begin
            balance_d = balance_q - POUND;
            if (pounds_q != 8'hFF) pounds_d = pounds_q + 8'd1;
          end else begin
            balance_d = balance_q - P20;
            if (p20_q != 8'hFF) p20_d = p20_q + 8'd1;
          end
        end else if (timer_q == ACK_LAST) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = S_SELECT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (fault_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    busy_d        = (state_d != S_IDLE);
    eject_pound_d = (state_d == S_EJECT_P);
    eject_20p_d   = (state_d == S_EJECT_20);
    done_d        = (state_d == S_DONE);
    fault_d       = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      balance_q     <= '0;
      pounds_q      <= '0;
      p20_q         <= '0;
      is_pound_q    <= 1'b0;
      req_prev_q    <= 1'b0;
      credit_clr_q  <= 1'b0;
      eject_pound_q <= 1'b0;
      eject_20p_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      balance_q     <= balance_d;
      pounds_q      <= pounds_d;
      p20_q         <= p20_d;
      is_pound_q    <= is_pound_d;
      req_prev_q    <= req_prev_d;
      credit_clr_q  <= credit_clr_d;
      eject_pound_q <= eject_pound_d;
      eject_20p_q   <= eject_20p_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  assign credit_clr  = credit_clr_q;
  assign eject_pound = eject_pound_q;
  assign eject_20p   = eject_20p_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign balance     = balance_q;
  assign pounds_out  = pounds_q;
  assign p20_out     = p20_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a behavioural hopper drives acks, and a
// greedy payout model predicts the coin sequence, counts, balance and outcome.
module tb_change_dispenser;
  localparam int W         = 12;
  localparam int PULSE_CYC = 4;
  localparam int ACK_TO    = 255;

  logic         clk = 1'b0;
  logic         reset, refund_req, pound_empty, p20_empty, hopper_ack, fault_clr;
  logic [W-1:0] credit;
  logic         credit_clr, eject_pound, eject_20p, busy, done, fault;
  logic [W-1:0] balance;
  logic [7:0]   pounds_out, p20_out;

  int n_checks = 0;
  int n_fail   = 0;

  change_dispenser #(.W(W), .PULSE_CYC(PULSE_CYC), .ACK_TIMEOUT(ACK_TO), .GAP_CYC(2)) dut (
    .clk(clk), .reset(reset), .refund_req(refund_req), .credit(credit),
    .pound_empty(pound_empty), .p20_empty(p20_empty), .hopper_ack(hopper_ack),
    .fault_clr(fault_clr), .credit_clr(credit_clr), .eject_pound(eject_pound),
    .eject_20p(eject_20p), .busy(busy), .done(done), .fault(fault),
    .balance(balance), .pounds_out(pounds_out), .p20_out(p20_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, int'({credit_clr, eject_pound, eject_20p, busy, done, fault}), 0);
    check({tag, "_bal"}, int'(balance), 0);
    check({tag, "_cnt"}, int'(pounds_out) + int'(p20_out), 0);
  endtask

  // withhold: 1-based coin index whose ack the hopper never returns (0 = none).
  // perturb: extra refund edge, credit change and a spurious ack during payout.
  task automatic run_refund(input string name, input int cr, input bit pe, input bit p2e,
                            input int withhold, input int ack_delay, input bit perturb);
    int  bal = cr;
    int  exp_coins[$];
    int  obs_coins[$];
    int  np = 0, n2 = 0, k = 0;
    bit  exp_fault = 0;
    int  n_clr = 0, n_done = 0, clr_cyc = -1, done_cyc = -1, fall_cyc = -1, end_cyc = -1;
    int  width = 0, coin_idx = 0, cd = 0;
    bit  prev_s = 0, spur = 0, finished = 0, s;
    int  v;

    // Greedy payout model straight from the coin rules.
    while (bal > 0) begin
      if (bal >= 100 && !pe) v = 100;
      else if (bal >= 20 && !p2e) v = 20;
      else begin exp_fault = 1; break; end
      k++;
      exp_coins.push_back(v);
      if (k == withhold) begin exp_fault = 1; break; end
      bal -= v;
      if (v == 100) np++; else n2++;
    end

    @(negedge clk);
    pound_empty = pe;
    p20_empty   = p2e;
    credit      = W'(cr);
    refund_req  = 1'b1;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      hopper_ack = 1'b0;
      if (perturb && cyc == 3) credit = W'($urandom_range(0, 4000));
      if (perturb && cyc == 6) refund_req = 1'b0;
      if (perturb && cyc == 8) refund_req = 1'b1;
      if (credit_clr) begin n_clr++; clr_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (eject_pound && eject_20p) check({name, "_both_strobes"}, 1, 0);
      s = eject_pound | eject_20p;
      if (s && !prev_s) obs_coins.push_back(eject_pound ? 100 : 20);
      if (s) width++;
      if (!s && prev_s) begin
        check({name, "_strobe_width"}, width, PULSE_CYC);
        width = 0;
        coin_idx++;
        fall_cyc = cyc;
        if (coin_idx != withhold) cd = ack_delay;
      end else if (spur) begin
        hopper_ack = 1'b1;
        spur = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin hopper_ack = 1'b1; spur = perturb; end
      end
      prev_s = s;
      if (done || fault) begin finished = 1; end_cyc = cyc; end
    end
    hopper_ack = 1'b0;
    check({name, "_finished"}, int'(finished), 1);

    check({name, "_coin_count"}, obs_coins.size(), exp_coins.size());
    for (int i = 0; i < exp_coins.size() && i < obs_coins.size(); i++)
      check($sformatf("%s_coin%0d", name, i), obs_coins[i], exp_coins[i]);
    check({name, "_pounds_out"}, int'(pounds_out), np);
    check({name, "_p20_out"}, int'(p20_out), n2);
    check({name, "_balance"}, int'(balance), bal);
    check({name, "_fault"}, int'(fault), int'(exp_fault));
    check({name, "_done_pulses"}, n_done, exp_fault ? 0 : 1);
    check({name, "_credit_clr_pulses"}, n_clr, 1);
    if (cr == 0) check({name, "_done_after_select"}, done_cyc - clr_cyc, 1);
    if (withhold != 0) check({name, "_timeout_cycles"}, end_cyc - fall_cyc, ACK_TO);

    if (exp_fault) begin
      check({name, "_busy_in_fault"}, int'(busy), 1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check({name, "_busy_after_clr"}, int'(busy), 0);
      check({name, "_fault_after_clr"}, int'(fault), 0);
      check({name, "_bal_kept"}, int'(balance), bal);
    end else begin
      @(negedge clk);
      check({name, "_busy_after_done"}, int'(busy), 0);
      check({name, "_done_single"}, int'(done), 0);
    end
    refund_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit got_strobe;
    reset = 1'b1; refund_req = 1'b0; pound_empty = 1'b0; p20_empty = 1'b0;
    hopper_ack = 1'b0; fault_clr = 1'b0; credit = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_refund("t1_260",      260, 0, 0, 0, 3, 0);
    run_refund("t2_p_empty",  100, 1, 0, 0, 3, 0);
    run_refund("t3_no_ack",   140, 0, 0, 2, 3, 0);
    run_refund("t4_zero",       0, 0, 0, 0, 3, 0);
    run_refund("t5_30",        30, 0, 0, 0, 2, 0);
    run_refund("t6_perturb",  360, 0, 0, 0, 2, 1);
    run_refund("both_empty",  120, 1, 1, 0, 2, 0);

    for (int i = 0; i < 12; i++)
      run_refund($sformatf("rnd%0d", i), $urandom_range(0, 70) * 10,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 0, $urandom_range(1, 6), $urandom_range(0, 1) == 1);

    // Reset in the middle of a pound strobe aborts the refund outright.
    @(negedge clk);
    pound_empty = 1'b0; p20_empty = 1'b0; credit = W'(500); refund_req = 1'b1;
    got_strobe = 0;
    for (int cyc = 0; cyc < 50 && !got_strobe; cyc++) begin
      @(negedge clk);
      if (eject_pound) got_strobe = 1;
    end
    check("t6_reach_strobe", int'(got_strobe), 1);
    reset = 1'b1; refund_req = 1'b0;
    @(negedge clk);
    check_all_zero("t6_mid_reset");
    reset = 1'b0;
    @(negedge clk);
    run_refund("post_reset", 220, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
